// File: rtl/axi_clint_slave.sv
// AXI4 slave holding the RISC-V CLINT registers (msip, mtimecmp, mtime) and their interrupt lines.
// Define CLINT_BURST_EN to allow multi-beat INCR bursts; otherwise multi-beat accesses get SLVERR.
module axi_clint_slave #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [63:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [63:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        msip_irq,
  output logic        mtip_irq
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [12:0] IDX_MSIP    = 13'h0000;
  localparam logic [12:0] IDX_CMP     = 13'h0800;
  localparam logic [12:0] IDX_MTIME   = 13'h17FF;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e       w_state_q, w_state_d;
  r_state_e       r_state_q, r_state_d;
  logic [15:0]    w_addr_q, w_addr_d, r_addr_q, r_addr_d;
  logic [7:0]     w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic           w_drop_q, w_drop_d, r_err_q, r_err_d;
  logic [1:0]     w_resp_q, w_resp_d;
  logic           awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic           arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;
  logic [63:0]    mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           msip_q, msip_d, mtip_q, mtip_d;

  logic           w_beat_c, w_hit_c, tick_c, rd_err_c;
  logic           wr_msip_c, wr_cmp_c, wr_mtime_c;
  logic [1:0]     beat_resp_c, w_merge_c, rd_resp_c;
  logic [12:0]    w_idx_c;
  logic [15:0]    rd_addr_c;
  logic [63:0]    rd_data_c;
  logic           unused_c;

  assign unused_c = ^{awaddr[63:16], araddr[63:16], awsize, arsize, awburst, arburst, rd_addr_c[2:0]};

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v, input logic [63:0] new_v,
                                              input logic [7:0] strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Write-side address decode for the current beat
  always_comb begin
    w_idx_c    = w_addr_q[15:3];
    w_hit_c    = (w_idx_c == IDX_MSIP) || (w_idx_c == IDX_CMP) || (w_idx_c == IDX_MTIME);
    wr_msip_c  = w_beat_c && (w_idx_c == IDX_MSIP);
    wr_cmp_c   = w_beat_c && (w_idx_c == IDX_CMP);
    wr_mtime_c = w_beat_c && (w_idx_c == IDX_MTIME);
  end

  // Write channel FSM
  always_comb begin
    w_state_d   = w_state_q;
    w_addr_d    = w_addr_q;
    w_cnt_d     = w_cnt_q;
    w_drop_d    = w_drop_q;
    w_resp_d    = w_resp_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    w_beat_c    = 1'b0;
    beat_resp_c = RESP_OKAY;
    w_merge_c   = w_resp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_state_d = W_DATA;
          w_addr_d  = awaddr[15:0];
          w_cnt_d   = awlen;
`ifdef CLINT_BURST_EN
          w_drop_d  = 1'b0;
`else
          w_drop_d  = (awlen != 8'd0);
`endif
          w_resp_d  = RESP_OKAY;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          w_beat_c = !w_drop_q && w_hit_c;
          if (w_drop_q)                        beat_resp_c = RESP_SLVERR;
          else if (!w_hit_c)                   beat_resp_c = RESP_DECERR;
          else if (wlast != (w_cnt_q == 8'd0)) beat_resp_c = RESP_SLVERR;
          // Encodings order numerically as DECERR > SLVERR > OKAY
          w_merge_c = (beat_resp_c > w_resp_q) ? beat_resp_c : w_resp_q;
          w_resp_d  = w_merge_c;
          if (wlast) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_merge_c;
          end else begin
            w_addr_d = w_addr_q + 16'd8;
            if (w_cnt_q != 8'd0) w_cnt_d = w_cnt_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Prescaler, register updates and interrupt compare
  always_comb begin
    tick_c     = (presc_q == PRESC_MAX);
    presc_d    = tick_c ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q;
    if (wr_mtime_c)  mtime_d = merge_bytes(mtime_q, wdata, wstrb);
    else if (tick_c) mtime_d = mtime_q + 64'd1;
    mtimecmp_d = wr_cmp_c ? merge_bytes(mtimecmp_q, wdata, wstrb) : mtimecmp_q;
    msip_d     = (wr_msip_c && wstrb[0]) ? wdata[0] : msip_q;
    mtip_d     = (mtime_q >= mtimecmp_q);
  end

  // Read data for the beat about to be presented: AR address when idle, next address otherwise
  always_comb begin
    rd_addr_c = (r_state_q == R_IDLE) ? araddr[15:0] : (r_addr_q + 16'd8);
    rd_data_c = 64'd0;
    rd_resp_c = RESP_OKAY;
    case (rd_addr_c[15:3])
      IDX_MSIP:  rd_data_c = {63'd0, msip_q};
      IDX_CMP:   rd_data_c = mtimecmp_q;
      IDX_MTIME: rd_data_c = mtime_q;
      default:   rd_resp_c = RESP_DECERR;
    endcase
  end

  // Read channel FSM
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef CLINT_BURST_EN
    rd_err_c  = 1'b0;
`else
    rd_err_c  = (r_state_q == R_IDLE) ? (arlen != 8'd0) : r_err_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_state_d = R_DATA;
          r_addr_d  = araddr[15:0];
          r_cnt_d   = arlen;
          r_err_d   = rd_err_c;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 8'd0);
          rdata_d   = rd_err_c ? 64'd0 : rd_data_c;
          rresp_d   = rd_err_c ? RESP_SLVERR : rd_resp_c;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_addr_d = r_addr_q + 16'd8;
            r_cnt_d  = r_cnt_q - 8'd1;
            rlast_d  = (r_cnt_q == 8'd1);
            rdata_d  = rd_err_c ? 64'd0 : rd_data_c;
            rresp_d  = rd_err_c ? RESP_SLVERR : rd_resp_c;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      w_addr_q   <= '0;
      r_addr_q   <= '0;
      w_cnt_q    <= '0;
      r_cnt_q    <= '0;
      w_drop_q   <= 1'b0;
      r_err_q    <= 1'b0;
      w_resp_q   <= RESP_OKAY;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      presc_q    <= '0;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      w_addr_q   <= w_addr_d;
      r_addr_q   <= r_addr_d;
      w_cnt_q    <= w_cnt_d;
      r_cnt_q    <= r_cnt_d;
      w_drop_q   <= w_drop_d;
      r_err_q    <= r_err_d;
      w_resp_q   <= w_resp_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
    end
  end

  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rlast    = rlast_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign msip_irq = msip_q;
  assign mtip_irq = mtip_q;

endmodule

// File: tb/tb_axi_clint_slave.sv
// Scoreboard bench for axi_clint_slave (TICK_DIV=1); expectations follow CLINT_BURST_EN if defined.
module tb_axi_clint_slave;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
`ifdef CLINT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk, rst_n;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready, msip_irq, mtip_irq;

  int total, bad;
  logic [63:0] exp_rdata_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic        exp_rlast_q[$];
  logic [1:0]  exp_bresp_q[$];

  // Reference model of the register file, updated on the same edges as the DUT
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_mtip, wr_live;
  logic [15:0] tb_waddr;

  axi_clint_slave dut (
    .ACLK(clk), .ARESETN(rst_n),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .msip_irq(msip_irq), .mtip_irq(mtip_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime <= 64'd0; m_cmp <= '1; m_msip <= 1'b0; m_mtip <= 1'b0;
    end else begin
      m_mtip <= (m_mtime >= m_cmp);
      if (wvalid && wready && wr_live && tb_waddr[15:3] == 13'h17FF) m_mtime <= bmerge(m_mtime, wdata, wstrb);
      else m_mtime <= m_mtime + 64'd1;
      if (wvalid && wready && wr_live && tb_waddr[15:3] == 13'h0800) m_cmp <= bmerge(m_cmp, wdata, wstrb);
      if (wvalid && wready && wr_live && tb_waddr[15:3] == 13'h0000 && wstrb[0]) m_msip <= wdata[0];
    end
  end

  function automatic logic [65:0] m_read(input logic [15:0] a);
    case (a[15:3])
      13'h0000: return {OKAY, 63'd0, m_msip};
      13'h0800: return {OKAY, m_cmp};
      13'h17FF: return {OKAY, m_mtime};
      default:  return {DECERR, 64'd0};
    endcase
  endfunction

  task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input int stall,
                         input string nm, output logic [63:0] got);
    logic [65:0] e;
    logic [63:0] ed;
    logic [1:0]  er;
    logic        el;
    int n;
    got = 64'd0;
    araddr = {48'd0, addr}; arlen = len; arvalid = 1'b1; n = 0;
    while (arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL %s ar_timeout arready=%b want 1", nm, arready); end
    for (int b = 0; b <= int'(len); b++) begin
      e = m_read(addr + 16'(8 * b));
      if (!BURST && len != 8'd0) e = {SLVERR, 64'd0};
      exp_rdata_q.push_back(e[63:0]);
      exp_rresp_q.push_back(e[65:64]);
      exp_rlast_q.push_back(b == int'(len));
    end
    @(posedge clk); #1; arvalid = 1'b0;
    total++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL %s r_latency rvalid=%b want 1", nm, rvalid); end
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      if (n >= 20) begin total++; bad++; $display("FAIL %s r_timeout rvalid=%b want 1", nm, rvalid); end
      ed = exp_rdata_q.pop_front(); er = exp_rresp_q.pop_front(); el = exp_rlast_q.pop_front();
      total++; if (rdata !== ed) begin bad++; $display("FAIL %s rdata beat%0d got=%h want=%h", nm, b, rdata, ed); end
      total++; if (rresp !== er) begin bad++; $display("FAIL %s rresp beat%0d got=%b want=%b", nm, b, rresp, er); end
      total++; if (rlast !== el) begin bad++; $display("FAIL %s rlast beat%0d got=%b want=%b", nm, b, rlast, el); end
      got = rdata;
      if (b == 0) begin
        for (int s = 1; s < stall; s++) begin
          @(posedge clk); #1;
          total++;
          if ({rvalid, rdata, rresp, rlast} !== {1'b1, ed, er, el}) begin
            bad++; $display("FAIL %s r_stable cyc%0d got=%b/%h/%b/%b want=1/%h/%b/%b",
                            nm, s, rvalid, rdata, rresp, rlast, ed, er, el);
          end
        end
      end
      rready = 1'b1; @(posedge clk); #1; rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input int nbeats,
                          input logic [63:0] data, input logic [7:0] strb, input logic [1:0] eresp,
                          input int bstall, input string nm);
    logic [1:0] er;
    int n;
    exp_bresp_q.push_back(eresp);
    awaddr = {48'd0, addr}; awlen = len; awvalid = 1'b1; n = 0;
    while (awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL %s aw_timeout awready=%b want 1", nm, awready); end
    @(posedge clk); #1; awvalid = 1'b0;
    total++;
    if (wready !== 1'b1) begin bad++; $display("FAIL %s w_latency wready=%b want 1", nm, wready); end
    wr_live = BURST || (len == 8'd0);
    for (int b = 0; b < nbeats; b++) begin
      tb_waddr = addr + 16'(8 * b); wdata = data; wstrb = strb; wlast = (b == nbeats - 1); wvalid = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({msip_irq, mtip_irq} !== {m_msip, m_mtip}) begin
        bad++; $display("FAIL %s irq beat%0d got=%b%b want=%b%b", nm, b, msip_irq, mtip_irq, m_msip, m_mtip);
      end
    end
    wvalid = 1'b0; wlast = 1'b0; wr_live = 1'b0;
    total++;
    if (bvalid !== 1'b1) begin bad++; $display("FAIL %s b_latency bvalid=%b want 1", nm, bvalid); end
    er = exp_bresp_q.pop_front();
    total++;
    if (bresp !== er) begin bad++; $display("FAIL %s bresp got=%b want=%b", nm, bresp, er); end
    for (int s = 1; s <= bstall; s++) begin
      @(posedge clk); #1;
      total++;
      if ({bvalid, bresp} !== {1'b1, er}) begin
        bad++; $display("FAIL %s b_stable cyc%0d got=%b/%b want=1/%b", nm, s, bvalid, bresp, er);
      end
    end
    bready = 1'b1; @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({awready, arready, wready, bvalid, rvalid, rlast, mtip_irq, msip_irq} !== 8'b1100_0000) begin
      bad++; $display("FAIL reset_hs got=%b want=11000000",
                      {awready, arready, wready, bvalid, rvalid, rlast, mtip_irq, msip_irq});
    end
    total++;
    if ({rdata, rresp, bresp} !== 68'd0) begin
      bad++; $display("FAIL reset_data got=%h/%b/%b want 0", rdata, rresp, bresp);
    end
  endtask

  task automatic test_read_cmp();
    logic [63:0] got;
    do_read(16'h4000, 8'd0, 0, "rd_cmp_reset", got);
    total++;
    if (got !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rd_cmp_const got=%h want all-ones", got); end
  endtask

  task automatic test_timer();
    bit seen;
    seen = 1'b0;
    do_write(16'hBFF8, 8'd0, 1, 64'd0, 8'hFF, OKAY, 0, "wr_mtime0");
    do_write(16'h4000, 8'd0, 1, 64'h20, 8'hFF, OKAY, 0, "wr_cmp20");
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk); #1;
      if (m_mtime == 64'h20) begin
        total++; if (mtip_irq !== 1'b0) begin bad++; $display("FAIL mtip_early got=%b want 0", mtip_irq); end
      end
      if (m_mtime == 64'h21) begin
        seen = 1'b1;
        total++; if (mtip_irq !== 1'b1) begin bad++; $display("FAIL mtip_rise got=%b want 1", mtip_irq); end
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL mtip_timeout mtime=%h want 21", m_mtime); end
    do_write(16'h4000, 8'd0, 1, '1, 8'hFF, OKAY, 0, "wr_cmp_max");
    total++;
    if (mtip_irq !== 1'b0) begin bad++; $display("FAIL mtip_drop got=%b want 0", mtip_irq); end
  endtask

  task automatic test_msip();
    logic [63:0] got;
    do_write(16'h0000, 8'd0, 1, 64'h1, 8'h01, OKAY, 0, "msip_set");
    total++; if (msip_irq !== 1'b1) begin bad++; $display("FAIL msip_set got=%b want 1", msip_irq); end
    do_write(16'h0000, 8'd0, 1, 64'h0, 8'h01, OKAY, 0, "msip_clr");
    total++; if (msip_irq !== 1'b0) begin bad++; $display("FAIL msip_clr got=%b want 0", msip_irq); end
    do_write(16'h0000, 8'd0, 1, '1, 8'hFF, OKAY, 0, "msip_ones");
    do_read(16'h0000, 8'd0, 0, "msip_rd", got);
    total++; if (got !== 64'h1) begin bad++; $display("FAIL msip_rd_const got=%h want 1", got); end
  endtask

  task automatic test_partial();
    logic [63:0] got, diff;
    do_write(16'hBFF8, 8'd0, 1, 64'hAAAA_0000_0000_0000, 8'hFF, OKAY, 0, "mtime_full");
    do_write(16'hBFF8, 8'd0, 1, 64'h1122_3344_5566_7788, 8'h0F, OKAY, 0, "mtime_part");
    do_read(16'hBFF8, 8'd0, 0, "mtime_rd", got);
    diff = got - 64'hAAAA_0000_5566_7788;
    total++;
    if (diff > 64'd8) begin bad++; $display("FAIL mtime_part_range got=%h want AAAA000055667788+few", got); end
  endtask

  task automatic test_unmapped();
    logic [63:0] got;
    do_read(16'h8000, 8'd0, 3, "unmapped_rd", got);
    do_write(16'h8000, 8'd0, 1, 64'h1234, 8'hFF, DECERR, 2, "unmapped_wr");
  endtask

  task automatic test_burst();
    logic [63:0] got;
    do_read(16'h4000, 8'd1, 0, "burst_rd", got);
    do_write(16'h4000, 8'd1, 2, 64'h5555_6666_7777_8888, 8'hFF, BURST ? DECERR : SLVERR, 0, "burst_wr");
    do_read(16'h4000, 8'd0, 0, "burst_wr_chk", got);
    do_write(16'h4000, 8'd1, 1, 64'h0000_1111_2222_3333, 8'h3C, SLVERR, 0, "wlast_early");
    do_read(16'h4000, 8'd0, 0, "wlast_early_chk", got);
  endtask

  task automatic test_back_to_back();
    logic [63:0] got, g2;
    fork
      do_write(16'h4000, 8'd0, 1, 64'h77, 8'hFF, OKAY, 0, "b2b_wr");
      begin @(posedge clk); #1; do_read(16'h4000, 8'd0, 0, "b2b_rd", got); end
    join
    do_read(16'h4000, 8'd0, 0, "b2b_rd2", g2);
    do_read(16'h0000, 8'd0, 0, "b2b_rd3", g2);
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    awaddr = 64'h4000; awlen = 8'd0; awvalid = 1'b1;
    araddr = 64'h4000; arlen = 8'd0; arvalid = 1'b1;
    @(posedge clk); #1; awvalid = 1'b0; arvalid = 1'b0;
    total++;
    if ({wready, rvalid} !== 2'b11) begin bad++; $display("FAIL mid_active got=%b want 11", {wready, rvalid}); end
    rst_n = 1'b0; #1;
    total++;
    if ({awready, arready, wready, rvalid, bvalid} !== 5'b11000) begin
      bad++; $display("FAIL mid_reset got=%b want 11000", {awready, arready, wready, rvalid, bvalid});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    do_read(16'h4000, 8'd0, 0, "post_reset_rd", got);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; wr_live = 1'b0; tb_waddr = '0;
    awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
    araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    test_reset();
    test_read_cmp();
    test_timer();
    test_msip();
    test_partial();
    test_unmapped();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_clint_slave.md
# axi_clint_slave

AXI4 slave implementing the core-local interruptor (CLINT) behind interconnect master port M00. It holds the RISC-V `msip`, `mtimecmp` and `mtime` registers and drives the machine software and timer interrupt lines back to the core. It consumes the address, data and response channels of the CPU's `clint` port after they pass through the interconnect.

## Interface
- `TICK_DIV`, default 1: `ACLK` cycles per `mtime` increment; legal range 1..65535.
- `ACLK` in 1: sole clock, rising edge.
- `ARESETN` in 1: reset, asynchronous assert, active-low.
- `awaddr` / `araddr` in 64: only bits [15:0] are decoded.
- `awlen` / `arlen` in 8: burst length minus 1.
- `awsize` / `arsize`, `awburst` / `arburst` in 3 / 2: accepted; the burst is always treated as INCR by 8 bytes.
- `awvalid` / `arvalid` in 1, `awready` / `arready` out 1: address handshakes.
- `wdata` in 64, `wstrb` in 8, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response.
- `rdata` out 64, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data.
- `msip_irq` out 1: equals `msip[0]`.
- `mtip_irq` out 1: registered result of `mtime >= mtimecmp` (unsigned compare).
- The lock, cache, prot, qos and region signals are not ports; the wrapper leaves them unconnected.

## Operation
- Register map, decoded on `addr[15:3]`:
  - 0x0000: `msip`. Bit 0 is writable; bits [63:1] read as 0.
  - 0x4000: `mtimecmp`, 64 bits.
  - 0xBFF8: `mtime`, 64 bits.
  - Any other address is unmapped. A read returns 0 with `DECERR` (2'b11). A write is discarded.
- Writes are byte-granular under `wstrb`. Bytes whose strobe bit is 0 keep their old value.
- `mtime` prescaler:
  - A prescaler counts 0..`TICK_DIV`-1.
  - `mtime` increments by 1 when the prescaler wraps. `mtime` wraps from 2^64-1 to 0.
  - A write beat to `mtime` wins over a same-cycle increment. The written bytes take the write data and unwritten bytes keep their old value, with no increment. The prescaler is not reset by the write.
- Write state machine:
  - W_IDLE: `awready`=1. An AW handshake latches the address and `awlen` and moves to W_DATA.
  - W_DATA: `wready`=1. Each W handshake writes one beat, then the address advances by 8 and the beat counter decrements. A handshake with `wlast`=1 moves to W_RESP.
  - W_RESP: `bvalid`=1. `bresp` is the worst response of the burst (`DECERR` > `SLVERR` > `OKAY`). A B handshake moves to W_IDLE.
  - Mismatch between `wlast` and the beat counter: the FSM follows `wlast` and `bresp` is `SLVERR`.
- Read state machine:
  - R_IDLE: `arready`=1. An AR handshake latches the address and `arlen` and moves to R_DATA.
  - R_DATA: `rvalid`=1. `rlast`=1 on the final beat. Each R handshake advances the address by 8. The handshake on the final beat moves to R_IDLE.
- The read and write FSMs are independent and may be active at the same time.
  - A read of a register in the same cycle a write beat updates it returns the pre-write value.
- `mtip_irq` and `msip_irq` update one cycle after the register change that causes them.

## Timing
- Reset values:
  - Registers: `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0.
  - Handshake outputs: `awready`=1, `arready`=1, `wready`=0, `bvalid`=0, `rvalid`=0.
  - Response and data outputs: `bresp`=0, `rresp`=0, `rdata`=0, `rlast`=0.
  - Interrupts: `mtip_irq`=0, `msip_irq`=0.
- Write latency:
  - `wready` is asserted the cycle after the AW handshake.
  - `bvalid` is asserted the cycle after the `wlast` handshake.
- Read latency:
  - `rvalid` is asserted the cycle after the AR handshake.
  - Subsequent beats are issued one per cycle while `rready`=1.
- Backpressure: `rdata`, `rresp` and `rlast` stay stable while `rvalid`=1 and `rready`=0. `bresp` stays stable while `bvalid`=1 and `bready`=0.
- Reset mid-transaction: both FSMs return to idle immediately. Pending B and R responses are dropped and partially written bursts are not rolled back.

## Configuration
- `CLINT_BURST_EN` defined: INCR bursts with `len` up to 255 are supported as described above.
- `CLINT_BURST_EN` undefined, reads with `arlen`≠0:
  - Every beat returns `rdata`=0 with `SLVERR`.
  - The beat count still honours `arlen`, with `rlast` on the final beat.
- `CLINT_BURST_EN` undefined, writes with `awlen`≠0:
  - All W beats are accepted and discarded.
  - `bresp` is `SLVERR`.
- `CLINT_BURST_EN` undefined, single-beat accesses behave identically to the defined case.

## Test plan
- After reset, single read of 0x4000 -> `rdata`=0xFFFF_FFFF_FFFF_FFFF, `rresp`=0, `rlast`=1, `rvalid` in the cycle after the AR handshake.
- Write `mtime`=0 and `mtimecmp`=0x20 with `TICK_DIV`=1 -> `mtip_irq` rises exactly one cycle after `mtime` reaches 0x20. A subsequent write of `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF drops `mtip_irq` one cycle after the write beat.
- Write 0x1 to 0x0000 with `wstrb`=0x01 -> `msip_irq`=1 and `bresp`=0. Write 0x0 -> `msip_irq`=0.
- Write 0x1122_3344_5566_7788 to 0xBFF8 with `wstrb`=0x0F while `mtime`=0xAAAA_0000_0000_0000 -> immediate read returns 0xAAAA_0000_5566_7788 plus the elapsed ticks.
- Read 0x8000 with `rready` held low for 3 cycles -> `rdata`=0, `rresp`=2'b11, both stable for 3 cycles, then the handshake completes.
- Read burst at 0x4000 with `arlen`=1:
  - With `CLINT_BURST_EN`: beat 0 returns `mtimecmp` with `OKAY`; beat 1 (0x4008) returns 0 with `DECERR` and `rlast`=1.
  - Without `CLINT_BURST_EN`: both beats return 0 with `SLVERR`.
